// File: rtl/tone_decoder.sv
// tone_decoder: measures the half-period of a square wave on tone_in and decodes
// which of the eight scale notes (a..ha) is sounding. A note is reported after
// MATCH_CNT consecutive half-periods fall into the same bin. It is dropped on a
// mismatch or after TIMEOUT clocks of silence.
// Optional feature: define TONE_SEG_EN to add an active-low 7-segment output
// 'seg' ({g,f,e,d,c,b,a}) that shows digit note_idx+1 while a note is locked.
module tone_decoder #(
    parameter int HP_A      = 1912,
    parameter int HP_B      = 1703,
    parameter int HP_C      = 1517,
    parameter int HP_D      = 1432,
    parameter int HP_E      = 1276,
    parameter int HP_F      = 1137,
    parameter int HP_G      = 1013,
    parameter int HP_HA     = 956,
    parameter int TOL       = 16,
    parameter int MATCH_CNT = 4,
    parameter int TIMEOUT   = 4095,
    parameter int CNT_W     = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tone_in,
    output logic       note_valid,
    output logic [2:0] note_idx,
    output logic [7:0] note_onehot
`ifdef TONE_SEG_EN
    ,
    output logic [6:0] seg
`endif
);

    localparam int MC_W = $clog2(MATCH_CNT + 1);
    localparam logic [MC_W-1:0]  MC_TGT    = MC_W'(MATCH_CNT);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam int HP_TAB [8] = '{HP_A, HP_B, HP_C, HP_D, HP_E, HP_F, HP_G, HP_HA};

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED
    } state_t;

    logic sync1, sync2, sync3;
    logic tone_edge;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   meas;
    logic       bin_hit;
    logic [2:0] bin_idx;

    state_t state, state_n;
    logic [2:0]      cand, cand_n;
    logic [2:0]      note, note_n;
    logic [MC_W-1:0] mc, mc_n;
    logic [MC_W-1:0] mc_cand;

    // Two-flop synchronizer plus a third flop, so either polarity of transition yields a one-clock pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= tone_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign tone_edge = sync2 ^ sync3;

    // Clocks since the last edge; saturates so a long silence still reads as TIMEOUT
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (tone_edge) begin
            cnt <= '0;
        end else if (cnt != TIMEOUT_V) begin
            cnt <= cnt + 1'b1;
        end
    end

    // The measured half-period counts the edge cycle itself, so it is one more than cnt
    assign meas = {1'b0, cnt} + (CNT_W + 1)'(1);

    // Map the measurement onto a note bin; scanning downwards lets the lowest index win on overlap
    always_comb begin
        bin_hit = 1'b0;
        bin_idx = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if ((int'(meas) + TOL >= HP_TAB[k]) && (int'(meas) <= HP_TAB[k] + TOL)) begin
                bin_hit = 1'b1;
                bin_idx = 3'(k);
            end
        end
    end

    // State, candidate note, match count and locked note registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cand  <= 3'd0;
            note  <= 3'd0;
            mc    <= '0;
        end else begin
            state <= state_n;
            cand  <= cand_n;
            note  <= note_n;
            mc    <= mc_n;
        end
    end

    // Next-state logic: edges drive acquisition and lock; a saturated counter means silence
    always_comb begin
        state_n = state;
        cand_n  = cand;
        note_n  = note;
        mc_n    = mc;
        mc_cand = (bin_idx == cand) ? mc + 1'b1 : MC_W'(1);
        if (tone_edge) begin
            case (state)
                IDLE: begin
                    state_n = ACQUIRE;
                    mc_n    = '0;
                end
                ACQUIRE: begin
                    if (!bin_hit) begin
                        mc_n = '0;
                    end else begin
                        cand_n = bin_idx;
                        mc_n   = mc_cand;
                        if (mc_cand >= MC_TGT) begin
                            state_n = LOCKED;
                            note_n  = bin_idx;
                        end
                    end
                end
                LOCKED: begin
                    if (!bin_hit) begin
                        state_n = ACQUIRE;
                        mc_n    = '0;
                    end else if (bin_idx != note) begin
                        state_n = ACQUIRE;
                        cand_n  = bin_idx;
                        mc_n    = MC_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    mc_n    = '0;
                end
            endcase
        end else if (cnt == TIMEOUT_V) begin
            state_n = IDLE;
            mc_n    = '0;
        end
    end

`ifdef TONE_SEG_EN
    // Active-low segment pattern {g,f,e,d,c,b,a} for digits 1..8
    function automatic logic [6:0] seg_digit(input logic [2:0] idx);
        case (idx)
            3'd0:    seg_digit = 7'h79;
            3'd1:    seg_digit = 7'h24;
            3'd2:    seg_digit = 7'h30;
            3'd3:    seg_digit = 7'h19;
            3'd4:    seg_digit = 7'h12;
            3'd5:    seg_digit = 7'h02;
            3'd6:    seg_digit = 7'h78;
            default: seg_digit = 7'h00;
        endcase
    endfunction
`endif

    // Register the outputs from the next-state values so they follow the deciding cycle by one clock
    always_ff @(posedge clk) begin
        if (reset) begin
            note_valid  <= 1'b0;
            note_idx    <= 3'd0;
            note_onehot <= 8'h00;
`ifdef TONE_SEG_EN
            seg         <= 7'h7F;
`endif
        end else if (state_n == LOCKED) begin
            note_valid  <= 1'b1;
            note_idx    <= note_n;
            note_onehot <= 8'h01 << note_n;
`ifdef TONE_SEG_EN
            seg         <= seg_digit(note_n);
`endif
        end else begin
            note_valid  <= 1'b0;
            note_idx    <= 3'd0;
            note_onehot <= 8'h00;
`ifdef TONE_SEG_EN
            seg         <= 7'h7F;
`endif
        end
    end

endmodule

// File: tb/tb_tone_decoder.sv
// tb_tone_decoder: drives square waves of chosen half-periods into tone_decoder
// and compares the outputs with a run-length note model.
// Define TONE_SEG_EN to include the 7-segment output in the comparisons.
module tb_tone_decoder;

    localparam int HP [8]   = '{1912, 1703, 1517, 1432, 1276, 1137, 1013, 956};
    localparam int TOL       = 16;
    localparam int MATCH_CNT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       tone_in;
    logic       note_valid;
    logic [2:0] note_idx;
    logic [7:0] note_onehot;
`ifdef TONE_SEG_EN
    logic [6:0] seg;
    localparam logic [6:0] SEG_DIGIT [8] = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
`endif

    int checks = 0;
    int errors = 0;

    // Model: a note is present once the trailing run of same-bin half-periods reaches MATCH_CNT
    bit armed;
    int run_bin;
    int run_len;
    int since_toggle;

    tone_decoder dut (
        .clk(clk),
        .reset(reset),
        .tone_in(tone_in),
        .note_valid(note_valid),
        .note_idx(note_idx),
        .note_onehot(note_onehot)
`ifdef TONE_SEG_EN
        ,
        .seg(seg)
`endif
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic int classify(input int m);
        for (int k = 0; k < 8; k++) begin
            if (m >= HP[k] - TOL && m <= HP[k] + TOL) return k;
        end
        return -1;
    endfunction

    function automatic bit modelValid();
        return armed && (run_len >= MATCH_CNT);
    endfunction

    task automatic modelSilence();
        armed   = 1'b0;
        run_len = 0;
    endtask

    task automatic modelTransition(input int m);
        int b;
        if (m >= 4097) modelSilence();
        if (!armed) begin
            armed   = 1'b1;
            run_len = 0;
        end else begin
            b = classify(m);
            if (b < 0) begin
                run_len = 0;
            end else if (run_len > 0 && b == run_bin) begin
                run_len++;
            end else begin
                run_bin = b;
                run_len = 1;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input bit exp_v, input int exp_i);
        logic [2:0] ei;
        logic [7:0] eo;
        ei = exp_v ? 3'(exp_i) : 3'd0;
        eo = exp_v ? (8'd1 << ei) : 8'd0;
        checks++;
        assert (note_valid === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s note_valid: observed %b expected %b", tag, note_valid, exp_v);
        end
        checks++;
        assert (note_idx === ei) else begin
            errors++;
            $error("[TB] FAIL %s note_idx: observed %0d expected %0d", tag, note_idx, ei);
        end
        checks++;
        assert (note_onehot === eo) else begin
            errors++;
            $error("[TB] FAIL %s note_onehot: observed %h expected %h", tag, note_onehot, eo);
        end
`ifdef TONE_SEG_EN
        checks++;
        assert (seg === (exp_v ? SEG_DIGIT[ei] : 7'h7F)) else begin
            errors++;
            $error("[TB] FAIL %s seg: observed %h expected %h", tag, seg, exp_v ? SEG_DIGIT[ei] : 7'h7F);
        end
`endif
    endtask

    task automatic checkModel(input string tag);
        checkOutput(tag, modelValid(), run_bin);
    endtask

    // Toggle tone_in so that this transition lands hp clocks after the previous one
    task automatic applyStimulus(input string tag, input int hp);
        repeat (hp - 4) @(negedge clk);
        since_toggle += hp - 4;
        if (since_toggle >= 4100) modelSilence();
        tone_in = ~tone_in;
        repeat (2) @(negedge clk);
        checkModel({tag, " pre"});
        repeat (2) @(negedge clk);
        modelTransition(since_toggle);
        since_toggle = 4;
        checkModel(tag);
    endtask

    initial begin
        reset        = 1'b1;
        tone_in      = 1'b0;
        armed        = 1'b0;
        run_bin      = 0;
        run_len      = 0;
        since_toggle = 100000;
        repeat (3) @(negedge clk);
        checkOutput("reset", 1'b0, 0);
        reset = 1'b0;

        $display("[TB] lock on note a");
        for (int i = 0; i < 5; i++) applyStimulus("a", 1912);
        checkOutput("a lock", 1'b1, 0);

        $display("[TB] switch a -> d");
        applyStimulus("d first", 1432);
        checkOutput("d first drop", 1'b0, 0);
        for (int i = 0; i < 3; i++) applyStimulus("d", 1432);
        checkOutput("d relock", 1'b1, 3);

        $display("[TB] note ha and its window edges");
        for (int i = 0; i < 4; i++) applyStimulus("ha", 956);
        checkOutput("ha lock", 1'b1, 7);
        for (int i = 0; i < 5; i++) applyStimulus("939", 939);
        checkOutput("939 none", 1'b0, 0);
        for (int i = 0; i < 4; i++) applyStimulus("940", 940);
        checkOutput("940 lock", 1'b1, 7);
        applyStimulus("939 break", 939);
        for (int i = 0; i < 4; i++) applyStimulus("972", 972);
        checkOutput("972 lock", 1'b1, 7);

        $display("[TB] unbinned half-period 1300");
        for (int i = 0; i < 20; i++) applyStimulus("1300", 1300);
        checkOutput("1300 none", 1'b0, 0);

        $display("[TB] silence timeout while locked on c");
        for (int i = 0; i < 4; i++) applyStimulus("c", 1517);
        checkOutput("c lock", 1'b1, 2);
        repeat (4092) @(negedge clk);
        since_toggle += 4092;
        checkOutput("c hold", 1'b1, 2);
        repeat (4) @(negedge clk);
        since_toggle += 4;
        modelSilence();
        checkModel("c timeout");
        checkOutput("c timeout literal", 1'b0, 0);

        $display("[TB] reset while locked on e");
        for (int i = 0; i < 5; i++) applyStimulus("e", 1276);
        checkOutput("e lock", 1'b1, 4);
        reset   = 1'b1;
        tone_in = 1'b0;
        @(negedge clk);
        checkOutput("mid reset", 1'b0, 0);
        reset = 1'b0;
        modelSilence();
        since_toggle = 100000;

        $display("[TB] randomized half-periods");
        for (int i = 0; i < 4; i++) applyStimulus("rand mix", int'($urandom_range(900, 2000)));
        begin
            int k;
            k = int'($urandom_range(5, 7));
            for (int i = 0; i < 5; i++)
                applyStimulus("rand run", HP[k] + int'($urandom_range(0, 2 * TOL)) - TOL);
            checkOutput("rand lock", 1'b1, k);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
